fp_mul_seq: RTL and testbench

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fp_mul_seq.sv | 117 +++++++++++
 tb/tb_fp_mul_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: radix-2 shift-add mantissa
// product over ITER cycles, then a normalise/pack cycle. Truncating rounding.
`timescale 1ns/1ps
module fp_mul_seq #(
  parameter int unsigned ITER = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] out,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow
);

  localparam int unsigned CW = $clog2(ITER + 1);
  localparam int unsigned MW = 24;
  localparam int unsigned PW = 2 * MW;
  localparam int unsigned EW = 10;

  typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

  state_t               state;
  logic                 sign_q;
  logic                 zero_q;
  logic                 inf_q;
  logic signed [EW-1:0] exp_q;
  logic [MW-1:0]        mcand;
  // Upper half accumulates; lower half starts as the multiplier and is
  // shifted out as product bits shift in.
  logic [PW-1:0]        prod;
  logic [CW-1:0]        cnt;

  logic [MW:0]          sum_c;
  logic signed [EW-1:0] exp_fin_c;
  logic [22:0]          mant_c;
  logic [7:0]           ea_c;
  logic [7:0]           eb_c;

  assign ea_c      = A[30:23];
  assign eb_c      = B[30:23];
  assign sum_c     = {1'b0, prod[PW-1:MW]} + (prod[0] ? {1'b0, mcand} : (MW+1)'(0));
  assign exp_fin_c = exp_q + $signed(EW'(prod[PW-1]));
  assign mant_c    = prod[PW-1] ? prod[PW-2:MW] : prod[PW-3:MW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      inf_q     <= 1'b0;
      exp_q     <= '0;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
      out       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= A[31] ^ B[31];
            zero_q <= (ea_c == 8'd0) || (eb_c == 8'd0);
            inf_q  <= (ea_c == 8'hFF) || (eb_c == 8'hFF);
            exp_q  <= $signed(EW'(ea_c) + EW'(eb_c) - EW'(127));
            mcand  <= {1'b1, A[22:0]};
            prod   <= {MW'(0), 1'b1, B[22:0]};
            cnt    <= CW'(ITER);
            busy   <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          prod <= {sum_c, prod[MW-1:1]};
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= NORM;
        end
        NORM: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          // Inf/NaN operands outrank zero operands; range checks apply last.
          if (inf_q) begin
            out       <= '0;
            overflow  <= 1'b1;
            underflow <= 1'b0;
          end else if (zero_q) begin
            out       <= {sign_q, 31'd0};
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end else if (exp_fin_c >= EW'(255)) begin
            out       <= '0;
            overflow  <= 1'b1;
            underflow <= 1'b0;
          end else if (exp_fin_c <= EW'(0)) begin
            out       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b1;
          end else begin
            out       <= {sign_q, exp_fin_c[7:0], mant_c};
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: hand-computed products, flags, latency,
// busy/done protocol, ignored starts and mid-operation reset.
`timescale 1ns/1ps
module tb_fp_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] out;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        underflow;

  int checks;
  int errors;

  fp_mul_seq #(.ITER(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .out       (out),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation: inputs are scrambled after capture; optional start poke while busy.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input logic exp_ov, input logic exp_un,
                        input bit poke);
    int  lat;
    bit  seen;
    bit  busy_ok;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_c0"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0; A = 32'h7FFFFFFF; B = 32'h12345678;
    lat = 0; seen = 1'b0; busy_ok = 1'b1;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = n;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
      if (poke && n == 5) start = 1'b1;
      if (poke && n == 7) start = 1'b0;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd25);
    chk({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    chk({tag, "_out"}, out, exp_out);
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ov));
    chk({tag, "_unf"}, 32'(underflow), 32'(exp_un));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_out_hold"}, out, exp_out);
  endtask

  initial begin
    int dcount;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_2x3",    32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 1'b0);
    run_op("mul_1p5xm2p5", 32'h3FC00000, 32'hC0200000, 32'hC0700000, 1'b0, 1'b0, 1'b0);

    run_op("ovf", 32'h7F000000, 32'h7F000000, 32'h00000000, 1'b1, 1'b0, 1'b1);
    dcount = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("ovf_no_extra_done", 32'(dcount), 32'd0);

    run_op("unf", 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 1'b0);
    run_op("neg_zero", 32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 1'b0);
    run_op("inf_op", 32'h7F800000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0);

    // Abort an operation with reset at cycle 10.
    @(negedge clk);
    A = 32'h40000000; B = 32'h40400000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out", out, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_flags", 32'({overflow, underflow}), 32'd0);
    dcount = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    run_op("after_abort", 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
